// File: rtl/kgp_control_unit.sv
// kgp_control_unit: multicycle IF/ID/EX/MEM/WB control FSM for KGP-RISC.
// Moore-style strobes are decoded from the current state and the latched IR.
// Optional macro KGP_CTRL_RETIRE_COUNT_EN adds the instr_retired counter port.
module kgp_control_unit #(
  parameter int unsigned START_ON_RESET = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] irout,
  output logic        readim,
  output logic        ldir,
  output logic        ldnpc,
  output logic        ldA,
  output logic        ldB,
  output logic        ldimm,
  output logic [1:0]  opcond,
  output logic        alusel1,
  output logic        alusel2,
  output logic        aluen,
  output logic        ldaluout,
  output logic [3:0]  alufunc,
  output logic        regwrite,
  output logic        writedmem,
  output logic        readdmem,
  output logic        ldlmd,
  output logic        selwb,
  output logic        branch,
  output logic        ldpc,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
`ifdef KGP_CTRL_RETIRE_COUNT_EN
  output logic [31:0] instr_retired,
`endif
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_halted;
  logic        r_illegal;
  logic        w_set_halt;
  logic        w_set_illegal;

  logic [1:0]  w_cls;
  logic [3:0]  w_fn;
  logic        w_is_alu;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_br;
  logic        w_is_jmp;
  logic        w_is_halt;
  logic        w_is_ill;
  logic        w_unused_ir;

  // Instruction class decode from the latched IR
  assign w_cls       = irout[31:30];
  assign w_fn        = irout[29:26];
  assign w_is_alu    = (w_cls[1] == 1'b0);
  assign w_is_load   = (w_cls == 2'b10) && !irout[26];
  assign w_is_store  = (w_cls == 2'b10) &&  irout[26];
  assign w_is_br     = (w_cls == 2'b11) && (w_fn[3:2] == 2'b00);
  assign w_is_jmp    = (w_cls == 2'b11) && (w_fn[3:2] == 2'b01);
  assign w_is_halt   = (w_cls == 2'b11) && (w_fn == 4'b1111);
  assign w_is_ill    = (w_cls == 2'b11) && w_fn[3] && (w_fn != 4'b1111);
  assign w_unused_ir = ^irout[25:0];

  assign state  = r_state;
  assign busy   = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted = r_halted;
  assign illegal = r_illegal;

  // State register and sticky halt/illegal flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= (START_ON_RESET != 0) ? S_IF : S_IDLE;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_halt)    r_halted  <= 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_next        = r_state;
    w_set_halt    = 1'b0;
    w_set_illegal = 1'b0;
    readim    = 1'b0;
    ldir      = 1'b0;
    ldnpc     = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    ldimm     = 1'b0;
    opcond    = 2'b00;
    alusel1   = 1'b0;
    alusel2   = 1'b0;
    aluen     = 1'b0;
    ldaluout  = 1'b0;
    alufunc   = 4'b0000;
    regwrite  = 1'b0;
    writedmem = 1'b0;
    readdmem  = 1'b0;
    ldlmd     = 1'b0;
    selwb     = 1'b0;
    branch    = 1'b0;
    ldpc      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_IF;
      end
      S_IF: begin
        readim = 1'b1;
        ldir   = 1'b1;
        ldnpc  = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        ldA   = 1'b1;
        ldB   = 1'b1;
        ldimm = 1'b1;
        if (w_is_jmp) begin
          branch = 1'b1;
          ldpc   = 1'b1;
          w_next = S_IF;
        end else if (w_is_halt || w_is_ill) begin
          w_set_halt    = 1'b1;
          w_set_illegal = w_is_ill;
          w_next        = S_HALT;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        aluen    = 1'b1;
        ldaluout = 1'b1;
        alufunc  = w_is_alu ? w_fn : 4'b0000;
        alusel1  = !w_is_br;
        alusel2  = (w_cls != 2'b00);
        if (w_is_br) opcond = irout[27:26];
        w_next   = w_is_alu ? S_WB : S_MEM;
      end
      S_MEM: begin
        if (w_is_load) begin
          readdmem = 1'b1;
          ldlmd    = 1'b1;
          w_next   = S_WB;
        end else if (w_is_store) begin
          writedmem = 1'b1;
          ldpc      = 1'b1;
          w_next    = S_IF;
        end else begin
          if (w_is_br) opcond = irout[27:26];
          ldpc   = 1'b1;
          w_next = S_IF;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        ldpc     = 1'b1;
        selwb    = w_is_load;
        w_next   = S_IF;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef KGP_CTRL_RETIRE_COUNT_EN
  logic [31:0] r_retired;

  // Count one retirement per ldpc pulse; wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (ldpc) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign instr_retired = r_retired;
`endif

endmodule

// File: tb/tb_kgp_control_unit.sv
// Self-checking bench for kgp_control_unit: directed table plus randomized
// instruction streams compared against a stage-path reference model.
module tb_kgp_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] irout;
  logic        readim, ldir, ldnpc, ldA, ldB, ldimm;
  logic [1:0]  opcond;
  logic        alusel1, alusel2, aluen, ldaluout;
  logic [3:0]  alufunc;
  logic        regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc;
  logic        busy, halted, illegal;
  logic [2:0]  state;
`ifdef KGP_CTRL_RETIRE_COUNT_EN
  logic [31:0] instr_retired;
`endif

  always #5 clk = ~clk;

  kgp_control_unit #(.START_ON_RESET(0)) dut (
    .clk(clk), .reset(reset), .start(start), .irout(irout),
    .readim(readim), .ldir(ldir), .ldnpc(ldnpc),
    .ldA(ldA), .ldB(ldB), .ldimm(ldimm), .opcond(opcond),
    .alusel1(alusel1), .alusel2(alusel2), .aluen(aluen), .ldaluout(ldaluout),
    .alufunc(alufunc), .regwrite(regwrite), .writedmem(writedmem),
    .readdmem(readdmem), .ldlmd(ldlmd), .selwb(selwb), .branch(branch),
    .ldpc(ldpc), .busy(busy), .halted(halted), .illegal(illegal),
`ifdef KGP_CTRL_RETIRE_COUNT_EN
    .instr_retired(instr_retired),
`endif
    .state(state)
  );

  typedef struct packed {
    logic       readim, ldir, ldnpc, ldA, ldB, ldimm;
    logic [1:0] opcond;
    logic       alusel1, alusel2, aluen, ldaluout;
    logic [3:0] alufunc;
    logic       regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc;
    logic       busy, halted, illegal;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          cycles;
    int          last_st;
    int          post_st;
    bit          h;
    bit          il;
  } vec_t;

  obs_t act;
  assign act = {readim, ldir, ldnpc, ldA, ldB, ldimm, opcond, alusel1, alusel2,
                aluen, ldaluout, alufunc, regwrite, writedmem, readdmem, ldlmd,
                selwb, branch, ldpc, busy, halted, illegal, state};

  int          vectors = 0;
  int          miscompares = 0;
  bit          m_halted = 1'b0;
  bit          m_illegal = 1'b0;
  logic [31:0] m_retired = '0;

  // Reference model: instruction kind -> ordered list of stage codes
  function automatic bit is_ill(input logic [31:0] ir);
    return (ir[31:30] == 2'b11) && ir[29] && (ir[29:26] != 4'hF);
  endfunction

  function automatic int path_len(input logic [31:0] ir);
    if (ir[31:30] != 2'b11) return (ir[31:30] == 2'b10 && !ir[26]) ? 5 : 4;
    return (ir[29:28] == 2'b00) ? 4 : 2;
  endfunction

  function automatic int path_state(input logic [31:0] ir, input int k);
    int p[$];
    p = '{1, 2};
    if (ir[31:30] != 2'b11 || ir[29:28] == 2'b00) p.push_back(3);
    if (ir[31] && !(ir[31:30] == 2'b11 && ir[29:28] != 2'b00)) p.push_back(4);
    if (!ir[31] || (ir[31:30] == 2'b10 && !ir[26])) p.push_back(5);
    return p[k];
  endfunction

  function automatic obs_t model(input logic [31:0] ir, input int st, input bit h, input bit il);
    obs_t o;
    bit load, store, br, jmp;
    load  = (ir[31:30] == 2'b10) && !ir[26];
    store = (ir[31:30] == 2'b10) && ir[26];
    br    = (ir[31:30] == 2'b11) && (ir[29:28] == 2'b00);
    jmp   = (ir[31:30] == 2'b11) && (ir[29:28] == 2'b01);
    o = '0;
    o.state  = st[2:0];
    o.busy   = (st != 0) && (st != 6);
    o.halted = h;
    o.illegal = il;
    case (st)
      1: begin o.readim = 1; o.ldir = 1; o.ldnpc = 1; end
      2: begin
        o.ldA = 1; o.ldB = 1; o.ldimm = 1;
        if (jmp) begin o.branch = 1; o.ldpc = 1; end
      end
      3: begin
        o.aluen = 1; o.ldaluout = 1;
        o.alufunc = (ir[31] == 1'b0) ? ir[29:26] : 4'b0000;
        o.alusel1 = !br;
        o.alusel2 = (ir[31:30] != 2'b00);
        if (br) o.opcond = ir[27:26];
      end
      4: begin
        if (load) begin o.readdmem = 1; o.ldlmd = 1; end
        else begin
          o.ldpc = 1;
          if (store) o.writedmem = 1;
          if (br) o.opcond = ir[27:26];
        end
      end
      5: begin o.regwrite = 1; o.ldpc = 1; o.selwb = load; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp32(input string name, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic check_obs(input string name, input obs_t e);
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
`ifdef KGP_CTRL_RETIRE_COUNT_EN
    cmp32({name, "_retired"}, instr_retired, m_retired);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    tick();
    m_halted = 1'b0; m_illegal = 1'b0; m_retired = '0;
    check_obs("reset", model(32'h0, 0, 1'b0, 1'b0));
    reset = 1'b1;
  endtask

  // Runs one instruction from S_IF; abort_at >= 0 pulls reset in that cycle
  task automatic run_instr(input logic [31:0] ir, input int abort_at, input bit rnd_start,
                           output int cycles, output int last_st);
    int   n;
    int   st;
    obs_t e;
    irout = ir;
    #1;
    n = path_len(ir);
    cycles = 0;
    last_st = -1;
    for (int k = 0; k < n; k++) begin
      st = path_state(ir, k);
      e  = model(ir, st, m_halted, m_illegal);
      check_obs($sformatf("ir%h_k%0d", ir, k), e);
      if (k == abort_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_halted = 1'b0; m_illegal = 1'b0; m_retired = '0;
        check_obs($sformatf("abort_ir%h", ir), model(ir, 0, 1'b0, 1'b0));
        cycles = -1;
        return;
      end
      if (rnd_start) start = 1'($urandom_range(0, 1));
      tick();
      if (e.ldpc) begin
        m_retired = m_retired + 32'd1;
        cycles = k + 1;
        last_st = st;
      end else if (k == n - 1) begin
        m_halted  = 1'b1;
        m_illegal = is_ill(ir);
        cycles = k + 1;
        last_st = st;
      end
    end
  endtask

  vec_t tab[8];
  int   cyc, lst, ab;
  logic [31:0] rir;

  initial begin
    tab[0] = '{32'h08000000, 4, 5, 1, 1'b0, 1'b0};
    tab[1] = '{32'h44000000, 4, 5, 1, 1'b0, 1'b0};
    tab[2] = '{32'h80000000, 5, 5, 1, 1'b0, 1'b0};
    tab[3] = '{32'h84000000, 4, 4, 1, 1'b0, 1'b0};
    tab[4] = '{32'hC8000000, 4, 4, 1, 1'b0, 1'b0};
    tab[5] = '{32'hD0000000, 2, 2, 1, 1'b0, 1'b0};
    tab[6] = '{32'hFC000000, 2, 2, 6, 1'b1, 1'b0};
    tab[7] = '{32'hE0000000, 2, 2, 6, 1'b1, 1'b1};

    reset = 1'b0; start = 1'b0; irout = '0;
    repeat (2) begin
      tick();
      check_obs("reset_hold", model(32'h0, 0, 1'b0, 1'b0));
    end
    reset = 1'b1;
    repeat (5) begin
      tick();
      check_obs("idle", model(32'h0, 0, 1'b0, 1'b0));
    end

    for (int i = 0; i < 8; i++) begin
      do_reset();
      start = 1'b1;
      tick();
      run_instr(tab[i].ir, -1, 1'b0, cyc, lst);
      cmp32($sformatf("cycles_%h", tab[i].ir), cyc, tab[i].cycles);
      cmp32($sformatf("last_state_%h", tab[i].ir), lst, tab[i].last_st);
      cmp32($sformatf("post_state_%h", tab[i].ir), {29'd0, state}, tab[i].post_st);
      cmp32($sformatf("halted_%h", tab[i].ir), {31'd0, halted}, {31'd0, tab[i].h});
      cmp32($sformatf("illegal_%h", tab[i].ir), {31'd0, illegal}, {31'd0, tab[i].il});
      if (tab[i].h) begin
        repeat (3) begin
          start = ~start;
          tick();
          check_obs("halt_hold", model(32'h0, 6, m_halted, m_illegal));
        end
      end
    end

    // Reset in S_EX of a load, after one retired R-type
    do_reset();
    start = 1'b1;
    tick();
    run_instr(32'h08000000, -1, 1'b0, cyc, lst);
    run_instr(32'h80000000, 2, 1'b0, cyc, lst);
    cmp32("load_abort", cyc, -1);
    start = 1'b0;
    repeat (3) begin
      tick();
      check_obs("post_abort_idle", model(32'h0, 0, 1'b0, 1'b0));
    end

    // Randomized instruction stream with occasional aborts
    do_reset();
    start = 1'b1;
    tick();
    for (int i = 0; i < 400; i++) begin
      rir = $urandom;
      ab  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, path_len(rir) - 1)) : -1;
      run_instr(rir, ab, 1'b1, cyc, lst);
      if (cyc == -1) begin
        start = 1'b1;
        tick();
      end else if (m_halted) begin
        repeat (2) begin
          start = 1'($urandom_range(0, 1));
          tick();
          check_obs("rnd_halt_hold", model(32'h0, 6, m_halted, m_illegal));
        end
        do_reset();
        start = 1'b1;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kgp_control_unit.md
Name: kgp_control_unit

Overview:
- Multicycle control FSM for the KGP-RISC processor. Sits directly upstream of the datapath and drives every datapath control strobe.
- Consumes the latched instruction (datapath IR output) and sequences each instruction through IF, ID, EX, MEM and WB.
- Outputs are Moore-style: decoded from the current state plus the IR, with no extra register stage.

Parameters:
- START_ON_RESET, 0, 1 = leave reset directly into S_IF instead of waiting in S_IDLE for start.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset on the next rising clk).
- start  in  1  level; begins fetching when the FSM is in S_IDLE.
- irout  in  32  latched instruction from the datapath IR.
- readim, ldir, ldnpc  out  1 each  IF strobes.
- ldA, ldB, ldimm  out  1 each  ID strobes.
- opcond  out  2  branch condition code to the datapath condition block.
- alusel1, alusel2, aluen, ldaluout  out  1 each  EX strobes; a mux select of 1 picks the second mux input.
- alufunc  out  4  ALU operation.
- regwrite, writedmem, readdmem, ldlmd, selwb, branch, ldpc  out  1 each  MEM/WB/PC strobes.
- busy  out  1  high in any state except S_IDLE and S_HALT.
- halted  out  1  sticky; set on HALT or an illegal instruction.
- illegal  out  1  sticky; set on an illegal encoding.
- state  out  3  current state code, for debug.

Behaviour:
- State encoding: S_IDLE=0, S_IF=1, S_ID=2, S_EX=3, S_MEM=4, S_WB=5, S_HALT=6.
- Decode uses cls = irout[31:30] and fn = irout[29:26].
  - cls 00: R-type ALU op.
  - cls 01: I-type ALU op.
  - cls 10: memory; irout[26]=0 is load, 1 is store.
  - cls 11: control, decoded by fn[3:2]: 00 conditional branch (cond = irout[27:26]); 01 jump; 11 with fn=1111 is HALT; anything else is illegal.
- Reset (reset=0 at a clk edge):
  - state <= S_IDLE, or S_IF when START_ON_RESET=1.
  - halted and illegal <= 0.
  - All strobes are 0 in the cycle after the reset edge.
  - Reset mid-instruction aborts the instruction; no partial ldpc/regwrite/writedmem is emitted afterwards.
- S_IDLE: all strobes 0. Go to S_IF when start=1.
- S_IF: readim=ldir=ldnpc=1. Always go to S_ID.
- S_ID: ldA=ldB=ldimm=1.
  - Jump: also branch=1 and ldpc=1, then go to S_IF.
  - HALT or illegal: no ldpc. Set halted (and illegal if applicable), go to S_HALT.
  - Otherwise go to S_EX.
- S_EX: aluen=ldaluout=1.
  - alufunc = fn for cls 00/01, 4'b0000 (ADD) otherwise.
  - alusel1 = 0 (NPC) for a branch, 1 (A) otherwise.
  - alusel2 = 0 for cls 00, 1 otherwise.
  - Next state: R-type/I-type go to S_WB; memory and branch go to S_MEM.
- S_MEM:
  - Load: readdmem=ldlmd=1, then go to S_WB.
  - Store: writedmem=1, ldpc=1, then go to S_IF.
  - Branch: ldpc=1, then go to S_IF.
- S_WB: regwrite=1, ldpc=1, selwb=1 for a load and 0 otherwise. Go to S_IF.
- opcond = irout[27:26] for a conditional branch in S_EX and S_MEM; 2'b00 (never taken, PC follows NPC) in every other state and class.
- Every strobe not listed for a state is 0.
- Exactly one ldpc pulse per retired instruction, in its final state.
- Cycle counts, IF through the ldpc cycle: R/I-type 4, load 5, store 4, branch 4, jump 2.
- irout must be stable from S_ID to the end of the instruction; the IR is loaded only in S_IF.
- S_HALT: all strobes 0, busy=0, halted=1. Leave only via reset; start is ignored.
- start is ignored in every state except S_IDLE.

Optional Feature:
- Macro: KGP_CTRL_RETIRE_COUNT_EN.
- Defined: adds output instr_retired (32 bits).
  - Reset value 0.
  - Increments by 1 on each clk edge where ldpc=1.
  - Wraps from 0xFFFFFFFF to 0.
  - HALT and illegal instructions are not counted.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, release, start=0 for 5 cycles -> state=0, all strobes 0, busy=0, halted=0.
- R-type: start=1, irout=0x08000000 (cls 00, fn 0010) -> ldir in cycle 1; in S_EX alufunc=4'b0010, alusel1=1, alusel2=0; in S_WB regwrite=1, selwb=0, ldpc=1; ldpc lands exactly 4 cycles after S_IF entry.
- Load then store:
  - irout=0x80000000 (load) -> S_MEM readdmem=ldlmd=1, S_WB selwb=1, 5 cycles total.
  - irout=0x84000000 (store) -> S_MEM writedmem=1, ldpc=1, regwrite never 1.
- Branch and jump:
  - irout=0xC8000000 (conditional, cond=10) -> alusel1=0, opcond=2'b10 in S_EX and S_MEM, ldpc in S_MEM.
  - irout=0xD0000000 (jump) -> branch=ldpc=1 in S_ID, back to S_IF next cycle.
- HALT/illegal:
  - irout=0xFC000000 -> S_HALT, halted=1, illegal=0; start toggling has no effect.
  - irout=0xE0000000 -> halted=1, illegal=1.
- Reset mid-instruction: assert reset=0 during S_EX of a load -> next cycle state=0, no readdmem/regwrite/ldpc pulses; with the macro defined, instr_retired=0.
